// File: rtl/pim_loader_pkg.sv
// Shared definitions for the PIM result loader: modes, FSM states, group count
// and the signed int8 saturation helper.
package pim_loader_pkg;

  localparam logic [2:0] PIM_READ     = 3'b011;
  localparam logic [2:0] PIM_PARALLEL = 3'b101;
  localparam logic [2:0] PIM_RBR      = 3'b110;

  localparam int GROUP_CNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Clamp a signed 32-bit value into the int8 range -128..127.
  function automatic logic [7:0] sat_int8(input logic [31:0] value);
    logic signed [31:0] v;
    v = signed'(value);
    if (v > 32'sd127) begin
      return 8'h7F;
    end else if (v < -32'sd128) begin
      return 8'h80;
    end else begin
      return value[7:0];
    end
  endfunction

endpackage

// File: rtl/pim_loader_fifo.sv
// Synchronous result FIFO with occupancy count and a registered head word
// (head reads as zero while the FIFO is empty).
module pim_loader_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WORD_W     = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [WORD_W-1:0]                 wr_data,
  input  logic                              pop,
  output logic [WORD_W-1:0]                 head,
  output logic [$clog2(FIFO_DEPTH):0]       count,
  output logic                              full,
  output logic                              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     rd_next_s;
  logic [AW:0]       count_r;
  logic [AW:0]       count_next_s;
  logic [WORD_W-1:0] head_r;
  logic [WORD_W-1:0] head_next_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign push_ok_s = push && (count_r != DEPTH_C);
  assign pop_ok_s  = pop && (count_r != CNT_ZERO);

  // Next occupancy and next head; a push landing on the new read slot bypasses memory.
  always_comb begin
    count_next_s = count_r;
    rd_next_s    = rd_ptr_r;
    head_next_s  = {WORD_W{1'b0}};
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    if (pop_ok_s) begin
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end
    if (count_next_s == CNT_ZERO) begin
      head_next_s = {WORD_W{1'b0}};
    end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = wr_data;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      head_r   <= {WORD_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
    end
  end

  assign head  = head_r;
  assign count = count_r;
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/pim_result_loader.sv
// Sequences the PIM output-buffer load interface and queues returned words for
// the bus. Define PIM_LOADER_PACK8_EN to pack four saturated int8 values per word.
module pim_result_loader #(
  parameter int FIFO_DEPTH = 8,
  parameter int WORD_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        before_load_mode_i,
  output logic              load_en_o,
  output logic [4:0]        load_cnt_o,
  input  logic [WORD_W-1:0] buf_data_i,
  output logic              rd_valid_o,
  output logic [WORD_W-1:0] rd_data_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  import pim_loader_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [5:0]    REM_ALL  = 6'(GROUP_CNT);

  state_e            state_r;
  logic [5:0]        remaining_r;
  logic [4:0]        load_cnt_r;
  logic              done_r;
  logic              err_r;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              load_en_s;
  logic              push_s;
  logic              pop_s;
  logic              last_load_s;
  logic              drain_done_s;
  logic [WORD_W-1:0] push_data_s;

  assign last_load_s  = (remaining_r == 6'd1);
  assign pop_s        = rd_ready_i && !fifo_empty_s;
  // The drain completes on the edge where the FIFO becomes (or already is) empty.
  assign drain_done_s = (fifo_count_s == CNT_ZERO) ||
                        ((fifo_count_s == CNT_ONE) && pop_s);

`ifdef PIM_LOADER_PACK8_EN
  logic [1:0]  pack_idx_r;
  logic [31:0] pack_r;
  logic [7:0]  sat_s;
  logic        completes_s;

  // Room is only needed on the load that finishes a packed word.
  always_comb begin
    sat_s       = sat_int8(buf_data_i);
    completes_s = (pack_idx_r == 2'd3) || last_load_s;
    load_en_s   = (state_r == ST_LOAD) && (!fifo_full_s || !completes_s);
    push_s      = load_en_s && completes_s;
    push_data_s = pack_r | ({24'd0, sat_s} << {pack_idx_r, 3'b000});
  end

  // Accumulates int8 lanes until a word is complete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pack_idx_r <= 2'd0;
      pack_r     <= 32'd0;
    end else if (load_en_s) begin
      if (completes_s) begin
        pack_idx_r <= 2'd0;
        pack_r     <= 32'd0;
      end else begin
        pack_idx_r <= pack_idx_r + 2'd1;
        pack_r     <= push_data_s;
      end
    end
  end
`else
  // Raw mode: every load pushes the buffer word unchanged.
  always_comb begin
    load_en_s   = (state_r == ST_LOAD) && !fifo_full_s;
    push_s      = load_en_s;
    push_data_s = buf_data_i;
  end
`endif

  // Control FSM: accepts starts, counts loads, and waits for the FIFO to drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      remaining_r <= 6'd0;
      load_cnt_r  <= 5'd31;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            if (before_load_mode_i == PIM_READ) begin
              remaining_r <= 6'd1;
              load_cnt_r  <= 5'd31;
              state_r     <= ST_LOAD;
            end else if ((before_load_mode_i == PIM_PARALLEL) ||
                         (before_load_mode_i == PIM_RBR)) begin
              remaining_r <= REM_ALL;
              load_cnt_r  <= 5'd31;
              state_r     <= ST_LOAD;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (load_en_s) begin
            remaining_r <= remaining_r - 6'd1;
            load_cnt_r  <= load_cnt_r - 5'd1;
            if (last_load_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  pim_loader_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WORD_W     (WORD_W)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push_s),
    .wr_data (push_data_s),
    .pop     (pop_s),
    .head    (rd_data_o),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign load_en_o  = load_en_s;
  assign load_cnt_o = load_cnt_r;
  assign rd_valid_o = !fifo_empty_s;
  assign busy_o     = (state_r != ST_IDLE);
  assign done_o     = done_r;
  assign err_o      = err_r;

endmodule
